// File: rtl/randomizer_pkg.sv
// Shared constants for the parallel scrambler: default LFSR geometry,
// the IEEE 802.16 randomizer polynomial and the reset seed.
package randomizer_pkg;

  localparam int          N_DEFAULT        = 15;
  localparam int          COUNT_W          = 16;

  // x^15 + x^14 + 1 expressed as a mask over state bits [14] and [13]
  localparam logic [14:0] POLY_IEEE_802_16 = 15'h6000;
  localparam logic [14:0] TAPS_DEFAULT     = POLY_IEEE_802_16;
  localparam logic [14:0] SEED_RST_DEFAULT = 15'h4A80;

endpackage

// File: rtl/lfsr_advance.sv
// Combinational W-step advance of a Fibonacci LFSR. The first generated
// bit lands in prbs_o[W-1] so it lines up with the earliest data bit.
module lfsr_advance
  import randomizer_pkg::*;
#(
  parameter int           W    = 8,
  parameter int           N    = N_DEFAULT,
  parameter logic [N-1:0] TAPS = N'(TAPS_DEFAULT)
) (
  input  logic [N-1:0] state_i,
  output logic [W-1:0] prbs_o,
  output logic [N-1:0] next_o
);

  // Unrolled bit-serial walk: feedback bit is both the PRBS output and the new LSB.
  always_comb begin
    logic [N-1:0] walk;
    logic         fb;
    prbs_o = '0;
    walk   = state_i;
    fb     = 1'b0;
    for (int k = 0; k < W; k++) begin
      fb               = ^(walk & TAPS);
      prbs_o[W-1-k]    = fb;
      walk             = {walk[N-2:0], fb};
    end
    next_o = walk;
  end

endmodule

// File: rtl/parallel_randomizer.sv
// Beat-parallel LFSR data scrambler with a one-deep output register,
// valid/ready handshake, frame restart from a programmable seed and a
// saturating per-frame beat counter.
module parallel_randomizer
  import randomizer_pkg::*;
#(
  parameter int           W        = 8,
  parameter int           N        = N_DEFAULT,
  parameter logic [N-1:0] TAPS     = N'(TAPS_DEFAULT),
  parameter logic [N-1:0] SEED_RST = N'(SEED_RST_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               load,
  input  logic [N-1:0]       seed_in,
  input  logic               bypass,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sof,
  input  logic [W-1:0]       data_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sof,
  output logic [W-1:0]       data_out,
  output logic [COUNT_W-1:0] beat_count
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  logic [N-1:0]       seed_q, seed_d;
  logic [N-1:0]       lfsr_q, lfsr_d;
  logic               out_valid_q, out_valid_d;
  logic               out_sof_q, out_sof_d;
  logic [W-1:0]       data_q, data_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic [N-1:0]       adv_start;
  logic [N-1:0]       adv_next;
  logic [W-1:0]       prbs_word;
  logic               accept;

  // Ready whenever the output slot is free or being drained this cycle; a
  // load cycle never takes a beat so seed and state updates cannot collide.
  assign in_ready  = enable & ~load & (~out_valid_q | out_ready);
  assign accept    = in_valid & in_ready;
  // A start-of-frame beat scrambles from the seed, not from the running state.
  assign adv_start = in_sof ? seed_q : lfsr_q;

  lfsr_advance #(
    .W    (W),
    .N    (N),
    .TAPS (TAPS)
  ) u_advance (
    .state_i (adv_start),
    .prbs_o  (prbs_word),
    .next_o  (adv_next)
  );

  // Next-state: seed load, beat acceptance, output drain, beat counting.
  always_comb begin
    seed_d      = seed_q;
    lfsr_d      = lfsr_q;
    out_valid_d = out_valid_q;
    out_sof_d   = out_sof_q;
    data_d      = data_q;
    count_d     = count_q;
    if (enable) begin
      if (load) begin
        seed_d = seed_in;
        lfsr_d = seed_in;
      end
      if (accept) begin
        lfsr_d      = adv_next;
        out_valid_d = 1'b1;
        out_sof_d   = in_sof;
        data_d      = bypass ? data_in : (data_in ^ prbs_word);
        if (in_sof) begin
          count_d = {{(COUNT_W-1){1'b0}}, 1'b1};
        end else if (count_q != COUNT_MAX) begin
          count_d = count_q + 1'b1;
        end
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers; reset drops any pending beat outright.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seed_q      <= SEED_RST;
      lfsr_q      <= SEED_RST;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      data_q      <= '0;
      count_q     <= '0;
    end else begin
      seed_q      <= seed_d;
      lfsr_q      <= lfsr_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      data_q      <= data_d;
      count_q     <= count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sof    = out_sof_q;
  assign data_out   = data_q;
  assign beat_count = count_q;

endmodule

// File: tb/tb_parallel_randomizer.sv
// Self-checking bench: an 8-bit-wide instance exercised with directed and
// random traffic, plus a 1-bit-wide instance used for the period check.
module tb_parallel_randomizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // W=8 instance
  logic        enable, load, bypass, in_valid, in_sof, out_ready;
  logic [14:0] seed_in;
  logic [7:0]  data_in;
  logic        in_ready, out_valid, out_sof;
  logic [7:0]  data_out;
  logic [15:0] beat_count;

  // W=1 instance
  logic        en1, ld1, iv1, sof1;
  logic [14:0] seed1;
  logic [0:0]  d1;
  logic        rdy1, ov1, osof1;
  logic [0:0]  dout1;
  logic [15:0] cnt1;
  logic        ordy1 = 1'b1;
  logic        byp1  = 1'b0;

  parallel_randomizer dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .seed_in(seed_in),
    .bypass(bypass), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .data_out(data_out), .beat_count(beat_count)
  );

  parallel_randomizer #(.W(1)) dut1 (
    .clk(clk), .reset(reset), .enable(en1), .load(ld1), .seed_in(seed1),
    .bypass(byp1), .in_valid(iv1), .in_ready(rdy1), .in_sof(sof1),
    .data_in(d1), .out_valid(ov1), .out_ready(ordy1),
    .out_sof(osof1), .data_out(dout1), .beat_count(cnt1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (W=8)
  logic [14:0] m_seed, m_state;
  logic        m_ov, m_osof;
  logic [7:0]  m_dout;
  logic [15:0] m_count;
  // Reference model state (W=1)
  logic [14:0] m1_seed, m1_state;
  logic        m1_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // PRBS from the polynomial x^15+x^14+1, generated one bit at a time,
  // earliest bit placed in the most significant position of the beat.
  task automatic prbs_bits(input int nbits, inout logic [14:0] st, output logic [7:0] w);
    logic b;
    w = '0;
    for (int k = 0; k < nbits; k++) begin
      b = st[14] ^ st[13];
      w[nbits-1-k] = b;
      st = {st[13:0], b};
    end
  endtask

  task automatic model_reset();
    m_seed = 15'h4A80; m_state = 15'h4A80;
    m_ov = 1'b0; m_osof = 1'b0; m_dout = 8'h00; m_count = 16'h0000;
    m1_seed = 15'h4A80; m1_state = 15'h4A80; m1_dout = 1'b0;
  endtask

  // One clock cycle on both instances with full model update and checks.
  task automatic cyc(input bit en, input bit ld, input logic [14:0] sd, input bit iv,
                     input logic [7:0] d, input bit sof, input bit byp, input bit ordy);
    logic        exp_rdy, acc;
    logic [7:0]  w;
    logic [14:0] st;
    enable = en; load = ld; seed_in = sd; in_valid = iv;
    data_in = d; in_sof = sof; bypass = byp; out_ready = ordy;
    #1;
    exp_rdy = en && !ld && (!m_ov || ordy);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    if (en1) chk("w1_in_ready", {31'd0, rdy1}, {31'd0, !ld1});
    @(posedge clk);
    #1;
    acc = iv && exp_rdy;
    if (en) begin
      if (ld) begin m_seed = sd; m_state = sd; end
      if (acc) begin
        st = sof ? m_seed : m_state;
        prbs_bits(8, st, w);
        m_state = st;
        m_dout  = byp ? d : (d ^ w);
        m_osof  = sof;
        m_ov    = 1'b1;
        if (sof) m_count = 16'd1;
        else if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
      end else if (ordy) begin
        m_ov = 1'b0;
      end
    end
    if (en1) begin
      if (ld1) begin m1_seed = seed1; m1_state = seed1; end
      else if (iv1) begin
        st = sof1 ? m1_seed : m1_state;
        prbs_bits(1, st, w);
        m1_state = st;
        m1_dout  = d1[0] ^ w[0];
        chk("w1_data", {31'd0, dout1}, {31'd0, m1_dout});
      end
    end
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    chk("out_sof", {31'd0, out_sof}, {31'd0, m_osof});
    chk("data_out", {24'd0, data_out}, {24'd0, m_dout});
    chk("beat_count", {16'd0, beat_count}, {16'd0, m_count});
  endtask

  logic [95:0] vec;
  logic [7:0]  b8, held;
  int          first_ret;

  initial begin
    model_reset();
    enable = 1'b1; load = 1'b0; seed_in = '0; bypass = 1'b0; in_valid = 1'b0;
    in_sof = 1'b0; data_in = '0; out_ready = 1'b1;
    en1 = 1'b0; ld1 = 1'b0; iv1 = 1'b0; sof1 = 1'b0; seed1 = '0; d1 = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sof", {31'd0, out_sof}, 32'd0);
    chk("rst_data_out", {24'd0, data_out}, 32'd0);
    chk("rst_beat_count", {16'd0, beat_count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;

    // first edge after release accepts; non-sof beat exercises LFSR reset value
    cyc(1, 0, 0, 1, 8'($urandom), 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, 8'($urandom), 0, 0, 1);

    // load while an output is pending and stalled: no accept, output survives
    cyc(1, 1, 15'h7FFF, 1, 8'($urandom), 0, 0, 0);
    chk("load_keeps_valid", {31'd0, out_valid}, 32'd1);
    cyc(1, 0, 0, 0, 8'h00, 0, 0, 1);

    // golden beats from seed 7FFF
    cyc(1, 0, 0, 1, 8'h00, 1, 0, 1);
    chk("gold_00_a", {24'd0, data_out}, 32'h00);
    cyc(1, 0, 0, 1, 8'h00, 0, 0, 1);
    chk("gold_00_b", {24'd0, data_out}, 32'h02);
    cyc(1, 0, 0, 1, 8'hFF, 1, 0, 1);
    chk("gold_ff_a", {24'd0, data_out}, 32'hFF);
    cyc(1, 0, 0, 1, 8'hFF, 0, 0, 1);
    chk("gold_ff_b", {24'd0, data_out}, 32'hFD);
    cyc(1, 0, 0, 1, 8'h00, 1, 0, 1);
    chk("restart_data", {24'd0, data_out}, 32'h00);
    chk("restart_count", {16'd0, beat_count}, 32'd1);

    // bypass mixed with scrambled beats
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 1, 8'($urandom), (i == 0), 1'($urandom), 1);

    // all-zero seed leaves data untouched
    vec = 96'hACBCD2114DAE1577C6DBF4C9;
    cyc(1, 1, 15'h0000, 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 12; i++) begin
      b8 = vec[95-8*i -: 8];
      cyc(1, 0, 0, 1, b8, (i == 0), 0, 1);
      chk("zero_seed", {24'd0, data_out}, {24'd0, b8});
    end

    // enable low: everything frozen, load ignored
    cyc(1, 1, 15'h1234, 0, 8'h00, 0, 0, 1);
    cyc(1, 0, 0, 1, 8'($urandom), 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 15'h7ABC, 1, 8'($urandom), 1, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 8'($urandom), 0, 0, 1);

    // five-cycle output stall mid-stream
    cyc(1, 1, 15'($urandom_range(1, 32767)), 0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      if (i == 6) held = data_out;
      cyc(1, 0, 0, 1, 8'($urandom), (i == 0), 0, !(i >= 6 && i < 11));
      if (i >= 6 && i < 11) begin
        chk("stall_hold", {24'd0, data_out}, {24'd0, held});
        chk("stall_ready", {31'd0, in_ready}, 32'd0);
      end
    end

    // random traffic
    for (int i = 0; i < 80; i++)
      cyc(($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0), 15'($urandom),
          1'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));

    // W=1 period run alongside W=8 counter saturation
    en1 = 1'b1; ld1 = 1'b1; seed1 = 15'h7FFF;
    cyc(1, 0, 0, 0, 8'h00, 0, 0, 1);
    ld1 = 1'b0; iv1 = 1'b1; d1 = 1'b0; sof1 = 1'b0;
    first_ret = 0;
    for (int i = 1; i <= 65540; i++) begin
      cyc(1, 0, 0, 1, 8'($urandom), (i == 1), 0, 1);
      if (first_ret == 0 && dut1.lfsr_q == 15'h7FFF) first_ret = i;
    end
    chk("w1_period", first_ret, 32'd32767);
    chk("count_saturate", {16'd0, beat_count}, 32'h0000FFFF);
    en1 = 1'b0; iv1 = 1'b0;

    // asynchronous reset with a pending output
    cyc(1, 0, 0, 1, 8'($urandom), 0, 0, 0);
    reset = 1'b0;
    #1;
    chk("async_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_beat_count", {16'd0, beat_count}, 32'd0);
    chk("async_data_out", {24'd0, data_out}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    chk("post_rst_lfsr", {17'd0, dut.lfsr_q}, 32'h4A80);
    cyc(1, 0, 0, 1, 8'($urandom), 0, 0, 1);
    cyc(1, 0, 0, 1, 8'($urandom), 0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
